// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one single-port data memory between the CPU load/store
// port (requester 0) and a loader/debug port (requester 1).
//
// Arbitration is round-robin. A requester may lock the memory for
// back-to-back accesses, up to MAX_LOCK consecutive grants while the other
// side is waiting. Grants are combinational. Writes commit at the edge that
// ends the grant cycle. Read data is registered and returns one cycle after
// the grant, with a one-cycle rvalid pulse.
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   reqN, weN, lockN     request, write enable, keep-ownership request
//   addrN, wdataN        access address and write data
//   gntN                 combinational grant (access accepted this cycle)
//   rvalidN, rdataN      registered read completion; rdata held until the next read
//   mem_we/addr/din      memory drive (all zero when nothing is granted)
//   mem_dout             memory combinational read data
module dm_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] lock_cnt, lock_cnt_nxt;
  logic       limit_hit;

  // Once the owner has used up its quota the count stays at MAX_LOCK, so an
  // owner that keeps the memory with nobody waiting still yields as soon as
  // the other side shows up.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v >= MAX_LOCK_C) return MAX_LOCK_C;
    return v + 8'd1;
  endfunction

  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    state_nxt    = IDLE;
    last_nxt     = last;
    lock_cnt_nxt = 8'd0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;

    limit_hit = (lock_cnt == MAX_LOCK_C);

    // Grant selection: owner first (unless its quota is spent and the other
    // side waits), then single requester, then round-robin on a tie.
    if (state == OWN0 && req0 && !(limit_hit && req1)) begin
      gnt0 = 1'b1;
    end else if (state == OWN1 && req1 && !(limit_hit && req0)) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      if (last) gnt0 = 1'b1;
      else      gnt1 = 1'b1;
    end else if (req0) begin
      gnt0 = 1'b1;
    end else if (req1) begin
      gnt1 = 1'b1;
    end

    // No access may reach the memory while reset is held.
    if (!rstn) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    // Ownership continues only if the owner was granted again and still
    // locks; a fresh lock (including a hand-over) restarts the count at 1.
    if (gnt0) begin
      last_nxt = 1'b0;
      mem_we   = we0;
      mem_addr = addr0;
      mem_din  = wdata0;
      if (lock0) begin
        state_nxt    = OWN0;
        lock_cnt_nxt = (state == OWN0) ? sat_inc(lock_cnt) : 8'd1;
      end
    end else if (gnt1) begin
      last_nxt = 1'b1;
      mem_we   = we1;
      mem_addr = addr1;
      mem_din  = wdata1;
      if (lock1) begin
        state_nxt    = OWN1;
        lock_cnt_nxt = (state == OWN1) ? sat_inc(lock_cnt) : 8'd1;
      end
    end
  end

  // ---- stage boundary: arbitration state ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // ---- stage boundary: read completion ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      if (gnt0 && !we0) rdata0 <= mem_dout;
      if (gnt1 && !we1) rdata1 <= mem_dout;
    end
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single-port data memory between the CPU load/store port (requester 0) and a loader/debug port (requester 1). The CPU and loader sit upstream; the data memory sits downstream. Arbitration is round-robin, with an optional bounded lock so one requester can hold the memory for back-to-back accesses. Grants are same-cycle, writes commit at the next clock edge, and read data returns one cycle later with a valid pulse. The CPU stalls on `gnt0`=0.

## Interface

Parameters:
- `ADDR_W`, 32, width of the address on the requester and memory sides.
- `DATA_W`, 32, data width.
- `MAX_LOCK`, 8, maximum consecutive grants a locking owner may hold while the other side waits; legal range 1..255.

Ports:
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `req0`, `req1` input 1: access request, held until granted.
- `we0`, `we1` input 1: 1 = write, 0 = read.
- `lock0`, `lock1` input 1: request to keep ownership after this grant.
- `addr0`, `addr1` input `ADDR_W`: access address.
- `wdata0`, `wdata1` input `DATA_W`: write data.
- `gnt0`, `gnt1` output 1: combinational; the access is accepted this cycle.
- `rvalid0`, `rvalid1` output 1: registered; read data valid, one-cycle pulse.
- `rdata0`, `rdata1` output `DATA_W`: registered read data, held until the next read completion on that port.
- `mem_we` output 1: memory write enable.
- `mem_addr` output `ADDR_W`: memory address.
- `mem_din` output `DATA_W`: memory write data.
- `mem_dout` input `DATA_W`: memory combinational read data.

## Operation

- **State machine:** `IDLE`, `OWN0`, `OWN1`.
  - `OWN`*i* is entered when *i* is granted with `lock`*i*=1.
  - The machine leaves to `IDLE` on any cycle where the owner is not granted or not locking.
- **Grant selection**, one requester per cycle, at most one of `gnt0`/`gnt1` high:
  - In `OWN`*i*, grant *i* if `req`*i*=1, except when the lock limit applies (see below).
  - Otherwise, if only one requester has `req` high, grant it.
  - If both have `req` high, grant the requester not equal to `last` (the last-granted index).
- **Lock limit.** `lock_cnt` (8 bits) counts consecutive grants to the owner while in `OWN`*i*.
  - When `lock_cnt` equals `MAX_LOCK` and the other side has `req` high, the lock is ignored for that cycle.
  - Normal round-robin then applies, so the other side wins. State returns to `IDLE` (or `OWN` of the new owner, if it locks).
  - `lock_cnt` resets to 1 on entry to `OWN`*i* and to 0 in `IDLE`.
- **`last` register.** Updated to the granted index on every grant. Reset value is 1, so requester 0 (CPU) wins the first tie.
- **Memory drive:**
  - Granted: `mem_addr`/`mem_din` = granted requester's `addr`/`wdata`, and `mem_we` = granted `we`.
  - No grant: `mem_we`=0, `mem_addr`=0, `mem_din`=0.
- **Read completion.** On a granted read, at the next rising edge `rdata`*i* ← `mem_dout` and `rvalid`*i* ← 1. `rvalid` deasserts the following cycle unless another read is granted.
- **Write completion.** A granted write produces no `rvalid`. The memory commits on the same rising edge that ends the grant cycle.
- **Requester protocol violations** (`req` dropped before grant, `we`/`addr` changing while ungranted) are permitted. Only values present in the grant cycle matter.

## Timing

- **Reset** (`rstn`=0, asynchronous): state `IDLE`, `last`=1, `lock_cnt`=0, `rvalid0`=`rvalid1`=0, `rdata0`=`rdata1`=0.
  - `mem_we` is 0 while `rstn`=0, regardless of `req`.
  - `gnt0`/`gnt1` are forced 0 while `rstn`=0.
- **Latencies:**
  - Grant: 0 cycles after `req` when uncontended.
  - Read data: 1 cycle after grant.
  - Throughput: one access per cycle in total.
- **Reset mid-read.** If reset asserts between the grant and the next edge, the pending `rvalid` is lost and the requester must retry.
- **Simultaneous lock expiry and owner release.** Owner release takes precedence; there is no extra cycle of round-robin penalty.
- **Wait bound.** Worst-case wait for a requester with `req` held is `MAX_LOCK`+1 cycles.

## Test plan

- **Reset then tie:** reset, then `req0`=`req1`=1, both reads, `addr0`=0x10, `addr1`=0x20, mem[0x10]=0xAAAA0001, mem[0x20]=0xBBBB0002.
  - Cycle 0: `gnt0`=1. Cycle 1: `gnt1`=1 and `rvalid0`=1 with `rdata0`=0xAAAA0001.
  - Cycle 2: `rvalid1`=1 with `rdata1`=0xBBBB0002.
- **Write then read, port 1 alone:** `we1`=1, `addr1`=0x40, `wdata1`=0x12345678, then a read of 0x40.
  - `mem_we`=1 only in the write cycle.
  - Next-cycle read returns 0x12345678 with `rvalid1`=1, and `rvalid0` stays 0 throughout.
- **Round-robin fairness:** both requesting continuously for 10 cycles, no lock → grants alternate 0,1,0,1,…, 5 grants each.
- **Lock with limit:** `MAX_LOCK`=4, `lock1`=1 and `req1`=1 held, `req0` raised at cycle 1.
  - `gnt1` for cycles 0–3, `gnt0` at cycle 4.
  - `gnt1` resumes at cycle 5 (new lock, `lock_cnt`=1).
- **Idle bus:** no `req` for 5 cycles → `mem_we`=0, `mem_addr`=0, `mem_din`=0, no `gnt`, no `rvalid`.
- **Asynchronous reset mid-lock:** `rstn` pulled low at a non-edge time while in `OWN1`.
  - `rvalid`/`rdata` clear immediately.
  - After release, a tie grants requester 0 first.
